histogram_readout: RTL and testbench

- Read-out engine for the bin memory filled by histogram_unit.
- On START, sweeps every bin 0..MAX_NUMBER through a synchronous-read memory port and streams (bin, count) pairs over a valid/ready interface.
- Accumulates the total sample count and the peak bin during the sweep.
- Optionally clears each bin after it is read, so the next accumulation run starts from zero.

---
 rtl/hist_pkg.sv | 13 +
 rtl/hist_peak_tracker.sv | 53 +++++
 rtl/histogram_readout.sv | 157 +++++++++++++++
 tb/tb_histogram_readout.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared types and default sizing for the histogram read-out engine.
package hist_pkg;

  localparam int HIST_SIZE       = 7;
  localparam int HIST_MAX_NUMBER = 127;
  localparam int ADDR_W          = $clog2(HIST_MAX_NUMBER);

  typedef enum logic [2:0] {IDLE, RD, WT, PR, CLR, DN} readout_state_t;

  typedef logic [ADDR_W-1:0]    bin_addr_t;
  typedef logic [HIST_SIZE-1:0] bin_cnt_t;

endpackage

// File: rtl/hist_peak_tracker.sv
// Running total and peak bin over the counts accepted during one sweep.
// Ties keep the earlier (lower) bin because only a strictly larger count wins.
module hist_peak_tracker #(
  parameter int SIZE   = 7,
  parameter int ADDR_W = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   update_i,
  input  logic [ADDR_W-1:0]      bin_i,
  input  logic [SIZE-1:0]        count_i,
  output logic [SIZE+ADDR_W-1:0] total_o,
  output logic [ADDR_W-1:0]      peak_bin_o
);

  logic [SIZE+ADDR_W-1:0] total_q, total_d;
  logic [SIZE-1:0]        peak_q, peak_d;
  logic [ADDR_W-1:0]      peak_bin_q, peak_bin_d;

  always_comb begin
    total_d    = total_q;
    peak_d     = peak_q;
    peak_bin_d = peak_bin_q;
    if (clear_i) begin
      total_d    = '0;
      peak_d     = '0;
      peak_bin_d = '0;
    end else if (update_i) begin
      total_d = total_q + (SIZE+ADDR_W)'(count_i);
      if (count_i > peak_q) begin
        peak_d     = count_i;
        peak_bin_d = bin_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_q    <= '0;
      peak_q     <= '0;
      peak_bin_q <= '0;
    end else begin
      total_q    <= total_d;
      peak_q     <= peak_d;
      peak_bin_q <= peak_bin_d;
    end
  end

  assign total_o    = total_q;
  assign peak_bin_o = peak_bin_q;

endmodule

// File: rtl/histogram_readout.sv
// Sweeps bins 0..MAX_NUMBER of the histogram memory and streams (bin, count) pairs.
// Define HIST_READOUT_CLEAR_ON_READ_EN to zero each bin right after it is accepted.
module histogram_readout
  import hist_pkg::*;
#(
  parameter int  SIZE       = HIST_SIZE,
  parameter int  MAX_NUMBER = HIST_MAX_NUMBER,
  localparam int BIN_W      = $clog2(MAX_NUMBER)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [BIN_W-1:0]      mem_addr,
  output logic                  mem_rd,
  input  logic [SIZE-1:0]       mem_rdata,
  output logic                  mem_we,
  output logic [SIZE-1:0]       mem_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic [SIZE-1:0]       out_count,
  output logic [SIZE+BIN_W-1:0] total,
  output logic [BIN_W-1:0]      peak_bin
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(MAX_NUMBER);

  // Output handshake: a pair transfers on a rising CLK when out_valid and
  // out_ready are both high; once raised, out_valid/out_bin/out_count hold
  // until that transfer happens.

  readout_state_t   state_q;
  logic             busy_q;
  logic             done_q;
  logic             mem_rd_q;
  logic             out_valid_q;
  logic [BIN_W-1:0] mem_addr_q;
  logic [BIN_W-1:0] out_bin_q;
  logic [SIZE-1:0]  out_count_q;

  logic start_ok;
  logic handshake;
  logic last_bin;

  assign start_ok  = (state_q == IDLE) && START;
  assign handshake = (state_q == PR) && out_valid_q && out_ready;
  assign last_bin  = (out_bin_q == LAST_BIN);

`ifdef HIST_READOUT_CLEAR_ON_READ_EN
  logic mem_we_q;
  assign mem_we = mem_we_q;
`else
  assign mem_we = 1'b0;
`endif
  assign mem_wdata = '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      out_bin_q   <= '0;
      out_count_q <= '0;
`ifdef HIST_READOUT_CLEAR_ON_READ_EN
      mem_we_q    <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      mem_rd_q <= 1'b0;
`ifdef HIST_READOUT_CLEAR_ON_READ_EN
      mem_we_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q    <= RD;
            busy_q     <= 1'b1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= '0;
          end
        end
        RD: state_q <= WT;
        WT: begin
          out_count_q <= mem_rdata;
          out_bin_q   <= mem_addr_q;
          out_valid_q <= 1'b1;
          state_q     <= PR;
        end
        PR: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
`ifdef HIST_READOUT_CLEAR_ON_READ_EN
            // mem_addr still points at the bin just accepted.
            state_q  <= CLR;
            mem_we_q <= 1'b1;
`else
            if (last_bin) begin
              state_q <= DN;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= RD;
              mem_addr_q <= mem_addr_q + BIN_W'(1);
              mem_rd_q   <= 1'b1;
            end
`endif
          end
        end
`ifdef HIST_READOUT_CLEAR_ON_READ_EN
        CLR: begin
          if (last_bin) begin
            state_q <= DN;
            busy_q  <= 1'b0;
          end else begin
            state_q    <= RD;
            mem_addr_q <= mem_addr_q + BIN_W'(1);
            mem_rd_q   <= 1'b1;
          end
        end
`endif
        DN: begin
          done_q     <= 1'b1;
          mem_addr_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hist_peak_tracker #(
    .SIZE   (SIZE),
    .ADDR_W (BIN_W)
  ) u_peak (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clear_i    (start_ok),
    .update_i   (handshake),
    .bin_i      (out_bin_q),
    .count_i    (out_count_q),
    .total_o    (total),
    .peak_bin_o (peak_bin)
  );

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_histogram_readout.sv
// Bench for histogram_readout: memory model, per-cycle stream checker, directed sweeps.
module tb_histogram_readout;

  localparam int SIZE = 7;
  localparam int NB   = 128;
  localparam int AW   = 7;
  localparam int TW   = SIZE + AW;
`ifdef HIST_READOUT_CLEAR_ON_READ_EN
  localparam int CPB = 4;
`else
  localparam int CPB = 3;
`endif
  localparam int SWEEP_LAT = NB * CPB + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            out_ready = 1'b1;
  logic            busy, done, mem_rd, mem_we, out_valid;
  logic [AW-1:0]   mem_addr, out_bin, peak_bin;
  logic [SIZE-1:0] mem_rdata = '0;
  logic [SIZE-1:0] mem_wdata, out_count;
  logic [TW-1:0]   total;

  logic [SIZE-1:0] mem [NB];
  logic [SIZE-1:0] saved [NB];

  logic [AW+SIZE-1:0] exp_q[$];
  int exp_total, exp_peak;
  int checks, failures;
  int cyc, start_cyc, done_count, we_count;
  bit first_pending, lat_check_en, stall_en;
  bit prev_stall, prev_valid;
  logic [AW-1:0]   prev_bin;
  logic [SIZE-1:0] prev_count;

  histogram_readout dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .BUSY      (busy),
    .DONE      (done),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_count (out_count),
    .total     (total),
    .peak_bin  (peak_bin)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- synchronous-read memory model ----------------
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // ---------------- sink ready driver ----------------
  always @(posedge clk) begin
    #1 out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    logic [AW+SIZE-1:0] e;
    if (!rst) begin
      if (mem_rd || mem_we) chk("rd_we_exclusive", int'(mem_rd && mem_we), 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_bin", out_bin, prev_bin);
        chk("stall_count", out_count, prev_count);
      end
      if (out_valid && !out_ready) chk("stall_no_mem", int'(mem_rd || mem_we), 0);
      if (out_valid && !prev_valid && first_pending) begin
        chk("first_valid_lat", cyc - start_cyc, 2);
        first_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_handshake: got bin %0d expected no transfer", out_bin);
        end else begin
          e = exp_q.pop_front();
          chk("hs_bin", out_bin, int'(e[AW+SIZE-1:SIZE]));
          chk("hs_count", out_count, int'(e[SIZE-1:0]));
        end
      end
      if (mem_we) begin
        we_count++;
        chk("wdata_zero", mem_wdata, 0);
      end
      if (done) begin
        done_count++;
        chk("done_bins_left", exp_q.size(), 0);
        chk("done_total", total, exp_total);
        chk("done_peak_bin", peak_bin, exp_peak);
        chk("done_busy_low", busy, 0);
        if (lat_check_en) chk("done_latency", cyc - start_cyc, SWEEP_LAT);
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_bin   = out_bin;
      prev_count = out_count;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks / model ----------------
  task automatic build_model();
    int best;
    exp_q.delete();
    exp_total = 0;
    exp_peak  = 0;
    best      = 0;
    for (int b = 0; b < NB; b++) begin
      exp_q.push_back({AW'(b), mem[b]});
      exp_total += int'(mem[b]);
      if (int'(mem[b]) > best) begin
        best     = int'(mem[b]);
        exp_peak = b;
      end
    end
  endtask

  task automatic start_sweep();
    @(posedge clk);
    #1 start = 1'b1;
    build_model();
    we_count      = 0;
    first_pending = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit seen;
    d0   = done_count;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(posedge clk);
      if (done_count != d0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no DONE expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_bin(input int bin, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (out_valid && int'(out_bin) == bin) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL bin_timeout: got no bin %0d expected it within %0d cycles", bin, budget);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_bin"}, out_bin, 0);
    chk({tag, "_out_count"}, out_count, 0);
    chk({tag, "_total"}, total, 0);
    chk({tag, "_peak_bin"}, peak_bin, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, nz;
    rst = 1'b1;
    start = 1'b0;
    stall_en = 1'b0;
    lat_check_en = 1'b0;
    for (int b = 0; b < NB; b++) mem[b] = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Ramp: bin k holds k.
    for (int b = 0; b < NB; b++) mem[b] = SIZE'(b % 128);
    lat_check_en = 1'b1;
    start_sweep();
    wait_done(2000);
    chk("ramp_total_literal", total, 8128);
    chk("ramp_peak_literal", peak_bin, 127);
    d0 = done_count;
    repeat (5) @(posedge clk);
    #1;
    chk("ramp_single_done", done_count, d0);
    chk("ramp_busy_after", busy, 0);
    chk("ramp_total_hold", total, 8128);

    // Tie: equal counts at bins 5 and 40.
    for (int b = 0; b < NB; b++) mem[b] = '0;
    mem[5]  = 7'd9;
    mem[40] = 7'd9;
    start_sweep();
    wait_done(2000);
    chk("tie_total_literal", total, 18);
    chk("tie_peak_literal", peak_bin, 5);

    // Random data, unstalled then with random backpressure.
    for (int b = 0; b < NB; b++) begin
      saved[b] = SIZE'($urandom_range(0, 127));
      mem[b]   = saved[b];
    end
    start_sweep();
    wait_done(2000);
    for (int b = 0; b < NB; b++) mem[b] = saved[b];
    lat_check_en = 1'b0;
    stall_en = 1'b1;
    start_sweep();
    wait_done(8000);
    stall_en = 1'b0;
    lat_check_en = 1'b1;

    // START re-asserted mid-sweep at bin 60 is ignored.
    for (int b = 0; b < NB; b++) mem[b] = SIZE'($urandom_range(0, 127));
    start_sweep();
    d0 = done_count;
    wait_bin(60, 1000);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(2000);
    repeat (5) @(posedge clk);
    #1 chk("restart_single_done", done_count, d0 + 1);

    // Asynchronous reset while presenting bin 30, then a fresh sweep.
    for (int b = 0; b < NB; b++) mem[b] = SIZE'($urandom_range(1, 127));
    start_sweep();
    wait_bin(30, 1000);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    exp_q.delete();
    first_pending = 1'b0;
    @(negedge clk) rst = 1'b0;
    start_sweep();
    wait_done(2000);

`ifdef HIST_READOUT_CLEAR_ON_READ_EN
    for (int b = 0; b < NB; b++) mem[b] = SIZE'($urandom_range(1, 127));
    start_sweep();
    wait_done(2000);
    chk("clear_we_per_bin", we_count, NB);
    nz = 0;
    for (int b = 0; b < NB; b++) if (mem[b] != '0) nz++;
    chk("clear_mem_zero", nz, 0);
    start_sweep();
    wait_done(2000);
    chk("clear_second_total", total, 0);
    chk("clear_second_peak", peak_bin, 0);
`else
    nz = we_count;
    chk("no_clear_we_count", nz, 0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
